output_ctrl: RTL and testbench

Back-end counterpart of the PolyEval input stage. It accepts pairs of evaluation results, one left word and one right word, with a valid/ready handshake. It buffers them in a small pair FIFO and serializes them onto a single-word output stream, left word first, with downstream backpressure. The word order on `data_o` is the same order that the input stage consumed, so an input→core→output loopback preserves stream order.

---
 rtl/polyeval_pkg.sv | 16 +
 rtl/output_ctrl_pair_fifo.sv | 51 +++++
 rtl/output_ctrl.sv | 72 +++++++
 tb/tb_output_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/polyeval_pkg.sv
// Shared PolyEval types: default word width, result pair payload, serializer half select.
package polyeval_pkg;

  localparam int unsigned WID_D_DFLT = 32;

  typedef struct packed {
    logic [WID_D_DFLT-1:0] left;
    logic [WID_D_DFLT-1:0] right;
  } res_pair_t;

  typedef enum logic {
    HALF_L = 1'b0,
    HALF_R = 1'b1
  } half_t;

endpackage : polyeval_pkg

// File: rtl/output_ctrl_pair_fifo.sv
// Pair FIFO: wrap-bit pointers, full/empty flags and an occupancy count.
module pair_fifo #(
  parameter int unsigned WID_E   = 64,
  parameter int unsigned DEPTH_P = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WID_E-1:0]           wr_data,
  input  logic                       pop,
  output logic [WID_E-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH_P):0]   fill
);

  localparam int unsigned AW = $clog2(DEPTH_P);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WID_E-1:0] mem [DEPTH_P];

  // Status derived purely from the registered pointers.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    fill  = wr_ptr - rd_ptr;
    head  = mem[rd_ptr[AW-1:0]];
  end

  // Storage and pointer update; a refused push or an empty pop leaves state alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH_P); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule : pair_fifo

// File: rtl/output_ctrl.sv
// Back-end output stage: buffers result pairs and serializes them left word first.
module output_ctrl
  import polyeval_pkg::*;
#(
  parameter int unsigned WID_D   = WID_D_DFLT,
  parameter int unsigned DEPTH_P = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WID_D-1:0]           res_left,
  input  logic [WID_D-1:0]           res_right,
  input  logic                       res_vld_i,
  output logic                       res_rdy_o,
  output logic [WID_D-1:0]           data_o,
  output logic                       dt_vld_o,
  input  logic                       dt_rdy_i,
  output logic [$clog2(DEPTH_P):0]   fill_o,
  output logic                       ovf_err_o
);

  localparam int unsigned WID_E = 2 * WID_D;

  logic [WID_E-1:0] head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  half_t            sel;

  // Handshake decode; ready and valid come only from registered FIFO state.
  always_comb begin
    res_rdy_o = !full;
    dt_vld_o  = !empty;
    push      = res_vld_i && !full;
    pop       = dt_vld_o && dt_rdy_i && (sel == HALF_R);
    data_o    = '0;
    if (dt_vld_o) begin
      data_o = (sel == HALF_R) ? head[WID_D-1:0] : head[WID_E-1:WID_D];
    end
  end

  pair_fifo #(
    .WID_E   (WID_E),
    .DEPTH_P (DEPTH_P)
  ) u_pair_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data ({res_left, res_right}),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .fill    (fill_o)
  );

  // Serializer half select and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= HALF_L;
      ovf_err_o <= 1'b0;
    end else begin
      if (res_vld_i && full) begin
        ovf_err_o <= 1'b1;
      end
      if (dt_vld_o && dt_rdy_i) begin
        sel <= (sel == HALF_L) ? HALF_R : HALF_L;
      end
    end
  end

endmodule : output_ctrl

// File: tb/tb_output_ctrl.sv
// Self-checking bench for output_ctrl: directed test plan plus random traffic vs a queue model.
module tb_output_ctrl;
  import polyeval_pkg::*;

  localparam int unsigned WID_D   = 32;
  localparam int unsigned DEPTH_P = 2;

  logic                     clk;
  logic                     rst_n;
  logic [WID_D-1:0]         res_left;
  logic [WID_D-1:0]         res_right;
  logic                     res_vld_i;
  logic                     res_rdy_o;
  logic [WID_D-1:0]         data_o;
  logic                     dt_vld_o;
  logic                     dt_rdy_i;
  logic [$clog2(DEPTH_P):0] fill_o;
  logic                     ovf_err_o;

  output_ctrl #(.WID_D(WID_D), .DEPTH_P(DEPTH_P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_left  (res_left),
    .res_right (res_right),
    .res_vld_i (res_vld_i),
    .res_rdy_o (res_rdy_o),
    .data_o    (data_o),
    .dt_vld_o  (dt_vld_o),
    .dt_rdy_i  (dt_rdy_i),
    .fill_o    (fill_o),
    .ovf_err_o (ovf_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of pending pairs, whether the head's left word is gone, sticky overflow.
  res_pair_t        m_q[$];
  bit               m_left_sent;
  bit               m_ovf;
  logic [WID_D-1:0] got_words[$];
  int               max_fill;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    logic [WID_D-1:0] exp_data;
    exp_data = '0;
    if (m_q.size() > 0) exp_data = m_left_sent ? m_q[0].right : m_q[0].left;
    chk({tag, "_vld"},  64'(dt_vld_o),  64'(m_q.size() > 0));
    chk({tag, "_data"}, 64'(data_o),    64'(exp_data));
    chk({tag, "_rdy"},  64'(res_rdy_o), 64'(m_q.size() < DEPTH_P));
    chk({tag, "_fill"}, 64'(fill_o),    64'(m_q.size()));
    chk({tag, "_ovf"},  64'(ovf_err_o), 64'(m_ovf));
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model at the edge.
  task automatic step(input bit vld, input logic [WID_D-1:0] l, input logic [WID_D-1:0] r,
                      input bit rdy);
    bit        was_full;
    res_pair_t p;
    check_outs("cyc");
    if (int'(fill_o) > max_fill) max_fill = int'(fill_o);
    res_vld_i = vld;
    res_left  = l;
    res_right = r;
    dt_rdy_i  = rdy;
    if (dt_vld_o && dt_rdy_i) got_words.push_back(data_o);
    @(posedge clk);
    was_full = (m_q.size() == DEPTH_P);
    if (vld && was_full) m_ovf = 1'b1;
    if (m_q.size() > 0 && rdy) begin
      if (m_left_sent) begin
        void'(m_q.pop_front());
        m_left_sent = 1'b0;
      end else begin
        m_left_sent = 1'b1;
      end
    end
    if (vld && !was_full) begin
      p.left  = l;
      p.right = r;
      m_q.push_back(p);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    res_vld_i = 1'b0;
    dt_rdy_i  = 1'b0;
    #1;
    m_q.delete();
    m_left_sent = 1'b0;
    m_ovf       = 1'b0;
    chk("rst_vld",  64'(dt_vld_o),  64'd0);
    chk("rst_data", 64'(data_o),    64'd0);
    chk("rst_fill", 64'(fill_o),    64'd0);
    chk("rst_rdy",  64'(res_rdy_o), 64'd1);
    chk("rst_ovf",  64'(ovf_err_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_words(input string tag, input logic [WID_D-1:0] exp[$]);
    chk({tag, "_len"}, 64'(got_words.size()), 64'(exp.size()));
    foreach (exp[i]) begin
      if (i < got_words.size()) chk({tag, "_word"}, 64'(got_words[i]), 64'(exp[i]));
      else                      chk({tag, "_word"}, 64'hdead_0000, 64'(exp[i]));
    end
  endtask

  initial begin
    logic [WID_D-1:0] exp[$];
    rst_n     = 1'b0;
    res_vld_i = 1'b0;
    res_left  = '0;
    res_right = '0;
    dt_rdy_i  = 1'b0;
    max_fill  = 0;
    @(negedge clk);
    do_reset();

    // Single pair straight through.
    got_words.delete();
    step(1'b1, 32'h11, 32'h22, 1'b1);
    chk("t1_left", 64'(data_o), 64'h11);
    step(1'b0, '0, '0, 1'b1);
    chk("t1_right", 64'(data_o), 64'h22);
    step(1'b0, '0, '0, 1'b1);
    chk("t1_vld_end", 64'(dt_vld_o), 64'd0);
    chk("t1_fill_end", 64'(fill_o), 64'd0);
    exp = '{32'h11, 32'h22};
    check_words("t1", exp);

    // Fill under backpressure, then offer a third pair to overflow.
    got_words.delete();
    step(1'b1, 32'hA, 32'hB, 1'b0);
    step(1'b1, 32'hC, 32'hD, 1'b0);
    chk("t2_fill", 64'(fill_o), 64'd2);
    chk("t2_rdy", 64'(res_rdy_o), 64'd0);
    chk("t2_hold", 64'(data_o), 64'hA);
    step(1'b1, 32'hE, 32'hF, 1'b0);
    chk("t3_ovf", 64'(ovf_err_o), 64'd1);
    chk("t3_hold", 64'(data_o), 64'hA);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1);
    exp = '{32'hA, 32'hB, 32'hC, 32'hD};
    check_words("t3", exp);
    chk("t3_ovf_sticky", 64'(ovf_err_o), 64'd1);

    // Ready toggling across one pair.
    got_words.delete();
    step(1'b1, 32'h5, 32'h6, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);
    chk("t4_hold_r", 64'(data_o), 64'h6);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    exp = '{32'h5, 32'h6};
    check_words("t4", exp);

    // Sustained 1 pair / 2 cycles across pointer wrap.
    do_reset();
    got_words.delete();
    exp.delete();
    max_fill = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'(32'h100 + 2 * i), 32'(32'h101 + 2 * i), 1'b1);
      step(1'b0, '0, '0, 1'b1);
      exp.push_back(32'(32'h100 + 2 * i));
      exp.push_back(32'(32'h101 + 2 * i));
    end
    step(1'b0, '0, '0, 1'b1);
    check_words("t5", exp);
    chk("t5_ovf", 64'(ovf_err_o), 64'd0);
    chk("t5_maxfill_le1", 64'(max_fill <= 1), 64'd1);

    // Reset after the left word has left.
    step(1'b1, 32'h77, 32'h88, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    chk("t6_mid", 64'(data_o), 64'h88);
    do_reset();
    got_words.delete();
    step(1'b1, 32'h1, 32'h2, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    exp = '{32'h1, 32'h2};
    check_words("t6", exp);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 45), $urandom(), $urandom(), ($urandom_range(0, 99) < 70));
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1);
    chk("rnd_drained", 64'(dt_vld_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_output_ctrl
